// File: rtl/johnson_phase_monitor_pkg.sv
// Shared definitions for Johnson-counter consumers: step-direction codes and
// phase-count derivation.
package johnson_phase_monitor_pkg;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_FWD  = 2'b01,
    DIR_BWD  = 2'b10,
    DIR_JUMP = 2'b11
  } dir_e;

  function automatic int unsigned nph_of(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/johnson_phase_monitor_decode.sv
// Combinational Johnson-code decoder: maps a WIDTH-bit code to {legal, phase index}.
module johnson_decode #(
  parameter int WIDTH = 4,
  parameter int PH_W  = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q_in,
  output logic             legal,
  output logic [PH_W-1:0]  phase_idx
);
  import johnson_phase_monitor_pkg::*;

  // Phases below WIDTH fill ones from the MSB; the rest drain them from the MSB.
  function automatic logic [WIDTH-1:0] code_of(input int unsigned k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k < WIDTH) return ~(ones >> k);
    else           return ones >> (k - WIDTH);
  endfunction

  always_comb begin
    legal     = 1'b0;
    phase_idx = '0;
    for (int unsigned k = 0; k < nph_of(WIDTH); k++) begin
      if (!legal && (q_in == code_of(k))) begin
        legal     = 1'b1;
        phase_idx = PH_W'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson phase monitor: registered phase decode, step direction, signed lap
// count and sticky error flag for a Johnson counter output.
module johnson_phase_monitor
  import johnson_phase_monitor_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAP_W = 8,
  localparam int NPH  = 2 * WIDTH,
  localparam int PH_W = $clog2(NPH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] q_in,
  input  logic             err_clr,
  output logic [PH_W-1:0]  phase,
  output logic [NPH-1:0]   phase_onehot,
  output logic             valid,
  output logic [1:0]       dir,
  output logic [LAP_W-1:0] lap_count,
  output logic             lap_pulse,
  output logic             err_sticky
);

  logic            w_legal;
  logic [PH_W-1:0] w_dec_ph;
  logic [PH_W-1:0] w_fwd_ph;
  logic [PH_W-1:0] w_bwd_ph;

  logic [PH_W-1:0]  r_phase,  n_phase;
  logic [NPH-1:0]   r_onehot, n_onehot;
  logic             r_valid,  n_valid;
  dir_e             r_dir,    n_dir;
  logic [LAP_W-1:0] r_lap,    n_lap;
  logic             r_pulse,  n_pulse;
  logic             r_err,    n_err;
  logic             w_err_set;

  johnson_decode #(.WIDTH(WIDTH), .PH_W(PH_W)) u_decode (
    .q_in      (q_in),
    .legal     (w_legal),
    .phase_idx (w_dec_ph)
  );

  // mod-NPH neighbours of the registered phase; NPH need not be a power of two
  assign w_fwd_ph = (r_phase == PH_W'(NPH - 1)) ? '0 : r_phase + 1'b1;
  assign w_bwd_ph = (r_phase == '0) ? PH_W'(NPH - 1) : r_phase - 1'b1;

  always_comb begin
    n_phase   = r_phase;
    n_valid   = r_valid;
    n_dir     = DIR_HOLD;
    n_lap     = r_lap;
    n_pulse   = 1'b0;
    w_err_set = 1'b0;

    if (!w_legal) begin
      n_valid   = 1'b0;
      w_err_set = 1'b1;
    end else if (!r_valid) begin
      n_phase = w_dec_ph;
      n_valid = 1'b1;
    end else if (w_dec_ph == r_phase) begin
      n_dir = DIR_HOLD;
    end else if (w_dec_ph == w_fwd_ph) begin
      n_dir   = DIR_FWD;
      n_phase = w_dec_ph;
      if (r_phase == PH_W'(NPH - 1)) begin
        n_lap   = r_lap + 1'b1;
        n_pulse = 1'b1;
      end
    end else if (w_dec_ph == w_bwd_ph) begin
      n_dir   = DIR_BWD;
      n_phase = w_dec_ph;
      if (r_phase == '0) begin
        n_lap   = r_lap - 1'b1;
        n_pulse = 1'b1;
      end
    end else begin
      n_dir     = DIR_JUMP;
      n_phase   = w_dec_ph;
      w_err_set = 1'b1;
    end

    n_err    = w_err_set ? 1'b1 : (err_clr ? 1'b0 : r_err);
    n_onehot = n_valid ? (NPH'(1) << n_phase) : '0;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_phase  <= '0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_dir    <= DIR_HOLD;
      r_lap    <= '0;
      r_pulse  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_phase  <= n_phase;
      r_onehot <= n_onehot;
      r_valid  <= n_valid;
      r_dir    <= n_dir;
      r_lap    <= n_lap;
      r_pulse  <= n_pulse;
      r_err    <= n_err;
    end
  end

  assign phase        = r_phase;
  assign phase_onehot = r_onehot;
  assign valid        = r_valid;
  assign dir          = r_dir;
  assign lap_count    = r_lap;
  assign lap_pulse    = r_pulse;
  assign err_sticky   = r_err;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor with hand-computed expectations.
module tb_johnson_phase_monitor;

  logic       clk;
  logic       clear;
  logic [3:0] q_in;
  logic       err_clr;
  logic [2:0] phase;
  logic [7:0] phase_onehot;
  logic       valid;
  logic [1:0] dir;
  logic [7:0] lap_count;
  logic       lap_pulse;
  logic       err_sticky;

  int n_checks = 0;
  int n_errors = 0;

  johnson_phase_monitor #(.WIDTH(4), .LAP_W(8)) dut (
    .clk          (clk),
    .clear        (clear),
    .q_in         (q_in),
    .err_clr      (err_clr),
    .phase        (phase),
    .phase_onehot (phase_onehot),
    .valid        (valid),
    .dir          (dir),
    .lap_count    (lap_count),
    .lap_pulse    (lap_pulse),
    .err_sticky   (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_ph, input logic [7:0] e_oh,
                           input logic e_v, input logic [1:0] e_dir, input logic [7:0] e_lap,
                           input logic e_pulse, input logic e_err);
    check({tag, ".phase"},  32'(phase),        32'(e_ph));
    check({tag, ".onehot"}, 32'(phase_onehot), 32'(e_oh));
    check({tag, ".valid"},  32'(valid),        32'(e_v));
    check({tag, ".dir"},    32'(dir),          32'(e_dir));
    check({tag, ".lap"},    32'(lap_count),    32'(e_lap));
    check({tag, ".pulse"},  32'(lap_pulse),    32'(e_pulse));
    check({tag, ".err"},    32'(err_sticky),   32'(e_err));
  endtask

  task automatic step(input logic [3:0] code);
    q_in = code;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fwd_codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                4'b1111, 4'b0111, 4'b0011, 4'b0001};

  initial begin
    clear   = 1'b1;
    err_clr = 1'b0;
    q_in    = 4'b0000;

    // 1: reset
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", 3'd0, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);

    // 2: one forward revolution
    clear = 1'b0;
    step(4'b0000);
    check_all("first", 3'd0, 8'h01, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step(fwd_codes[i]);
      check_all("fwd", 3'(i), 8'(1 << i), 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    end
    step(4'b0000);
    check_all("fwd_wrap", 3'd0, 8'h01, 1'b1, 2'b01, 8'h01, 1'b1, 1'b0);

    // 3: advance to 0011, then hold
    for (int i = 1; i < 7; i++) step(fwd_codes[i]);
    check_all("to6", 3'd6, 8'h40, 1'b1, 2'b01, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011);
      check_all("hold", 3'd6, 8'h40, 1'b1, 2'b00, 8'h01, 1'b0, 1'b0);
    end

    // 4: walk back to 0000, then backward wraps
    for (int i = 5; i >= 0; i--) begin
      step(fwd_codes[i]);
      check_all("bwd", 3'(i), 8'(1 << i), 1'b1, 2'b10, 8'h01, 1'b0, 1'b0);
    end
    step(4'b0001);
    check_all("bwd_wrap1", 3'd7, 8'h80, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      step(fwd_codes[i]);
      check_all("bwd2", 3'(i), 8'(1 << i), 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
    end
    step(4'b0001);
    check_all("bwd_wrap2", 3'd7, 8'h80, 1'b1, 2'b10, 8'hFF, 1'b1, 1'b0);

    // 5: illegal code with simultaneous err_clr
    err_clr = 1'b1;
    step(4'b1010);
    check_all("illegal", 3'd7, 8'h00, 1'b0, 2'b00, 8'hFF, 1'b0, 1'b1);
    err_clr = 1'b0;
    step(4'b0000);
    check_all("relock", 3'd0, 8'h01, 1'b1, 2'b00, 8'hFF, 1'b0, 1'b1);
    err_clr = 1'b1;
    step(4'b0000);
    check_all("errclr", 3'd0, 8'h01, 1'b1, 2'b00, 8'hFF, 1'b0, 1'b0);
    err_clr = 1'b0;

    // 6: jump, then clear mid-sequence
    step(4'b1110);
    check_all("jump", 3'd3, 8'h08, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b1);
    clear = 1'b1;
    step(4'b1100);
    check_all("midclear", 3'd0, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    clear = 1'b0;
    step(4'b1100);
    check_all("postclear", 3'd2, 8'h04, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
